// File: rtl/seq_shift_add_multiplier.sv
`timescale 1ns/1ps
// seq_shift_add_multiplier
//   Sequential shift-and-add multiplier with a start/ready handshake.
//   Operands are converted to magnitudes at accept. One multiplier bit is
//   consumed per clock, and the sign is applied to the accumulated magnitude
//   product in a final fix-up cycle. The product is held in a result register
//   until the next completion.
//
// Ports
//   clk          clock, all state changes on posedge
//   rst          synchronous active-high reset; aborts any multiply, clears out
//   start        request; accepted on an edge where ready=1
//   signed_mode  1 = operands/product are two's complement (sampled at accept)
//   in1          multiplier operand, WIDTH bits (sampled at accept)
//   in2          multiplicand operand, WIDTH bits (sampled at accept)
//   ready        high in IDLE and DONE
//   done         one-cycle pulse, out is new while high
//   out          2*WIDTH-bit product register
module seq_shift_add_multiplier #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  // Magnitude of an operand. For the most-negative value, -v wraps to the same
  // bit pattern, which read unsigned is exactly 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic signed [WIDTH-1:0] m;
    m = (is_signed && (v < 0)) ? -v : v;
    return m;
  endfunction

  // Two's complement negation of the magnitude product when the signs differ.
  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] mag,
                                               input logic negate);
    logic signed [PW-1:0] s;
    s = $signed(mag);
    return negate ? -s : s;
  endfunction

  state_t              state_q, state_d;
  logic [PW-1:0]       mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [PW-1:0]       acc_q, acc_d;
  logic [CW-1:0]       count_q, count_d;
  logic                neg_q, neg_d;
  logic [PW-1:0]       out_q, out_d;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    neg_d    = neg_q;
    out_d    = out_q;
    ready    = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
      end

      // iteration: one multiplier bit per clock
      S_RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        if ((count_q == LAST_STEP) || (EARLY_EXIT && (mplier_d == '0))) begin
          count_d = '0;
          state_d = S_FIX;
        end else begin
          count_d = count_q + CW'(1);
        end
      end

      // sign fix-up into the held result register
      S_FIX: begin
        out_d   = apply_sign(acc_q, neg_q);
        state_d = S_DONE;
      end

      S_DONE: begin
        ready   = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // accept: identical load from IDLE and from DONE (back-to-back)
    if (ready && start) begin
      mcand_d  = {{WIDTH{1'b0}}, magnitude($signed(in2), signed_mode)};
      mplier_d = magnitude($signed(in1), signed_mode);
      neg_d    = signed_mode & (in1[WIDTH-1] ^ in2[WIDTH-1]);
      acc_d    = '0;
      count_d  = '0;
      state_d  = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      out_q    <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
`timescale 1ns/1ps
module tb_seq_shift_add_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  st, smd;
  logic [2:0]  rdy, dn;
  logic [7:0]  a_in1, a_in2, b_in1, b_in2;
  logic [15:0] c_in1, c_in2;
  logic [15:0] oa, ob;
  logic [31:0] oc;
  logic [31:0] o [3];

  assign o[0] = {16'd0, oa};
  assign o[1] = {16'd0, ob};
  assign o[2] = oc;

  int checks = 0;
  int passes = 0;

  // instance 0: WIDTH=8 full iterations, 1: WIDTH=8 early exit, 2: WIDTH=16
  seq_shift_add_multiplier #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_a (
    .clk(clk), .rst(rst), .start(st[0]), .signed_mode(smd[0]),
    .in1(a_in1), .in2(a_in2), .ready(rdy[0]), .done(dn[0]), .out(oa));

  seq_shift_add_multiplier #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_b (
    .clk(clk), .rst(rst), .start(st[1]), .signed_mode(smd[1]),
    .in1(b_in1), .in2(b_in2), .ready(rdy[1]), .done(dn[1]), .out(ob));

  seq_shift_add_multiplier #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_c (
    .clk(clk), .rst(rst), .start(st[2]), .signed_mode(smd[2]),
    .in1(c_in1), .in2(c_in2), .ready(rdy[2]), .done(dn[2]), .out(oc));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // reference model: plain integer arithmetic on the operand values
  function automatic longint as_value(input logic [15:0] v, input int w, input bit sm);
    longint r;
    r = longint'(v) & ((longint'(1) << w) - 1);
    if (sm && v[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  function automatic longint model_product(input int w, input logic [15:0] a,
                                           input logic [15:0] b, input bit sm);
    return (as_value(a, w, sm) * as_value(b, w, sm)) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  function automatic int model_latency(input int w, input bit ee,
                                       input logic [15:0] a, input bit sm);
    longint m;
    int k;
    if (!ee) return w + 1;
    m = as_value(a, w, sm);
    if (m < 0) m = -m;
    k = 0;
    for (int i = 0; i < w; i++) if (((m >> i) & 1) != 0) k = i + 1;
    return ((k < 1) ? 1 : k) + 1;
  endfunction

  task automatic set_ops(input int inst, input logic [15:0] a, input logic [15:0] b);
    case (inst)
      0: begin a_in1 = a[7:0]; a_in2 = b[7:0]; end
      1: begin b_in1 = a[7:0]; b_in2 = b[7:0]; end
      default: begin c_in1 = a; c_in2 = b; end
    endcase
  endtask

  // One handshake; operands and mode are scrambled while the unit is busy.
  task automatic do_mul(input int inst, input logic [15:0] a, input logic [15:0] b,
                        input logic sm, output logic [31:0] p, output int lat);
    @(posedge clk); #1;
    chk("ready_before_start", rdy[inst], 1);
    set_ops(inst, a, b);
    smd[inst] = sm;
    st[inst]  = 1'b1;
    @(posedge clk); #1;
    st[inst] = 1'b0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      chk("ready_low_busy", rdy[inst], 0);
      set_ops(inst, 16'($urandom), 16'($urandom));
      smd[inst] = 1'($urandom);
      @(posedge clk); #1;
      lat++;
      if (dn[inst]) break;
    end
    if (!dn[inst]) chk("done_timeout", 0, 1);
    p = o[inst];
  endtask

  // protocol monitor
  logic [2:0]  dn_prev = 3'b000;
  logic        rst_prev = 1'b1;
  logic [31:0] o_prev [3] = '{32'd0, 32'd0, 32'd0};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (dn[i] === 1'b1) begin
        chk($sformatf("done_implies_ready%0d", i), rdy[i], 1);
        chk($sformatf("done_not_repeated%0d", i), dn_prev[i], 0);
      end
      if (o[i] !== o_prev[i])
        chk($sformatf("out_changes_only_at_done%0d", i), dn[i] | rst_prev, 1);
      o_prev[i] <= o[i];
    end
    dn_prev  <= dn;
    rst_prev <= rst;
  end

  typedef struct {
    int          inst;
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [31:0] exp_p;
    int          exp_lat;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    vec_t        tbl [$];
    logic [31:0] p;
    int          lat, n, seen;

    rst = 1'b1; st = '0; smd = '0;
    set_ops(0, 0, 0); set_ops(1, 0, 0); set_ops(2, 0, 0);

    tbl.push_back('{0, 16'h00FF, 16'h00FF, 1'b0, 32'd65025,     9});
    tbl.push_back('{0, 16'h0080, 16'h0080, 1'b1, 32'h4000,      9});
    tbl.push_back('{0, 16'h00FD, 16'h0007, 1'b1, 32'hFFEB,      9});
    tbl.push_back('{0, 16'h0005, 16'h0000, 1'b1, 32'h0,         9});
    tbl.push_back('{0, 16'h007F, 16'h0080, 1'b1, 32'hC080,      9});
    tbl.push_back('{1, 16'h0003, 16'h0064, 1'b0, 32'd300,       3});
    tbl.push_back('{1, 16'h0000, 16'h0037, 1'b0, 32'h0,         2});
    tbl.push_back('{1, 16'h0080, 16'h0003, 1'b1, 32'hFE80,      9});
    tbl.push_back('{1, 16'h00FF, 16'h0005, 1'b1, 32'hFFFB,      2});
    tbl.push_back('{1, 16'h0001, 16'h00C8, 1'b0, 32'd200,       2});
    tbl.push_back('{2, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 17});
    tbl.push_back('{2, 16'h8000, 16'h8000, 1'b1, 32'h40000000, 17});

    // reset state
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_out%0d", i), o[i], 0);
      chk($sformatf("reset_ready%0d", i), rdy[i], 1);
      chk($sformatf("reset_done%0d", i), dn[i], 0);
    end
    rst = 1'b0;

    // directed vectors
    foreach (tbl[i]) begin
      do_mul(tbl[i].inst, tbl[i].a, tbl[i].b, tbl[i].sm, p, lat);
      chk($sformatf("vec%0d_out", i), p, tbl[i].exp_p);
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
    end

    // back-to-back: start held high through the DONE cycle
    @(posedge clk); #1;
    set_ops(0, 12, 13); smd[0] = 1'b0; st[0] = 1'b1;
    @(posedge clk); #1;
    set_ops(0, 13, 1);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      n++;
      if (dn[0]) break;
    end
    chk("b2b_first_latency", n, 9);
    chk("b2b_first_out", o[0], 156);
    @(posedge clk); #1;
    st[0] = 1'b0;
    chk("b2b_second_accepted", rdy[0], 0);
    n = 1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      n++;
      if (dn[0]) break;
    end
    chk("b2b_done_spacing", n, 10);
    chk("b2b_second_out", o[0], 13);

    // reset during RUN step 4 of 6x7
    @(posedge clk); #1;
    set_ops(0, 6, 7); smd[0] = 1'b0; st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out", o[0], 0);
    chk("abort_ready", rdy[0], 1);
    chk("abort_done", dn[0], 0);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (dn[0]) seen++;
    end
    chk("abort_no_done", seen, 0);
    do_mul(0, 6, 7, 1'b0, p, lat);
    chk("after_abort_out", p, 42);
    chk("after_abort_latency", lat, 9);

    // randomized operands against the reference model
    for (int r = 0; r < 60; r++) begin
      int          inst, w;
      logic [15:0] a, b;
      logic        sm;
      inst = $urandom_range(0, 2);
      w    = (inst == 2) ? 16 : 8;
      a    = 16'($urandom);
      b    = 16'($urandom);
      sm   = 1'($urandom);
      if ((r % 7) == 0) a = a & 16'h0007;
      do_mul(inst, a, b, sm, p, lat);
      chk($sformatf("rand%0d_out", r), p, model_product(w, a, b, sm));
      chk($sformatf("rand%0d_latency", r), lat, model_latency(w, inst == 1, a, sm));
    end

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
